// File: rtl/spi_reg_receiver.sv
// -----------------------------------------------------------------------------
// spi_reg_receiver
//
// Write-only SPI (mode 0) target. 16-bit frames arrive MSB first on the chip
// pins and are committed to five 8-bit control registers that feed the PWM /
// output-enable stage. All pins are asynchronous to clk and are synchronised
// internally. Every output is driven straight from a flop.
//
// Frame layout: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
//
// Ports:
//   clk              in   system clock, rising edge
//   rst              in   synchronous active-high reset
//   sclk, copi, ncs  in   SPI pins (asynchronous)
//   en_reg_out_7_0   out  register 0x00
//   en_reg_out_15_8  out  register 0x01
//   en_reg_pwm_7_0   out  register 0x02
//   en_reg_pwm_15_8  out  register 0x03
//   pwm_duty_cycle   out  register 0x04
//   wr_strobe        out  one-cycle pulse on a register write
//   wr_addr          out  address of the last committed write
//   frame_err        out  one-cycle pulse on a frame with a bad bit count
// -----------------------------------------------------------------------------
module spi_reg_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_REGS    = 5,
   parameter int FRAME_BITS  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic [6:0] wr_addr,
   output logic       frame_err
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   localparam int              CNT_W      = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_BITS + 1);
   localparam int              FL_W       = $clog2(SYNC_STAGES + 1);
   localparam logic [FL_W-1:0] FL_DONE    = FL_W'(SYNC_STAGES);
   localparam logic [6:0]      NUM_REGS_A = 7'(NUM_REGS);

   // Synchroniser chains and edge-detect history
   logic [SYNC_STAGES-1:0] sclk_sync_r;
   logic [SYNC_STAGES-1:0] copi_sync_r;
   logic [SYNC_STAGES-1:0] ncs_sync_r;
   logic                   sclk_prev_r;
   logic                   ncs_prev_r;
   logic                   sclk_s;
   logic                   copi_s;
   logic                   ncs_s;
   logic                   sclk_rise_s;
   logic                   ncs_rise_s;
   logic                   ncs_fall_s;

   // Frame-start qualification after reset
   logic [FL_W-1:0]        flush_cnt_r;
   logic                   flush_done_s;
   logic                   armed_r;
   logic                   fall_pend_r;

   // Deserialiser and FSM
   logic [1:0]             state_r;
   logic [1:0]             state_nxt_s;
   logic [FRAME_BITS-1:0]  shift_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   start_s;
   logic                   shift_en_s;
   logic                   do_wr_s;
   logic                   do_err_s;
   logic [6:0]             frame_addr_s;
   logic [7:0]             frame_data_s;
   logic                   frame_rw_s;

   // Register file and registered status outputs
   logic [7:0]             regs_r [0:4];
   logic                   wr_strobe_r;
   logic [6:0]             wr_addr_r;
   logic                   frame_err_r;

   assign sclk_s       = sclk_sync_r[SYNC_STAGES-1];
   assign copi_s       = copi_sync_r[SYNC_STAGES-1];
   assign ncs_s        = ncs_sync_r[SYNC_STAGES-1];
   assign sclk_rise_s  = sclk_s & ~sclk_prev_r;
   assign ncs_rise_s   = ncs_s & ~ncs_prev_r;
   assign ncs_fall_s   = ~ncs_s & ncs_prev_r;
   assign flush_done_s = (flush_cnt_r == FL_DONE);

   assign frame_rw_s   = shift_r[FRAME_BITS-1];
   assign frame_addr_s = shift_r[FRAME_BITS-2 -: 7];
   assign frame_data_s = shift_r[7:0];

   // Pin synchronisers, preloaded with the idle bus pattern on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_r <= {SYNC_STAGES{1'b0}};
         copi_sync_r <= {SYNC_STAGES{1'b0}};
         ncs_sync_r  <= {SYNC_STAGES{1'b1}};
         sclk_prev_r <= 1'b0;
         ncs_prev_r  <= 1'b1;
      end else begin
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
         copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], copi};
         ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], ncs};
         sclk_prev_r <= sclk_s;
         ncs_prev_r  <= ncs_s;
      end
   end

   // Arming: after reset the chains hold a fake "ncs high", so a frame that
   // was already running would look like a fresh falling edge. Only accept
   // a falling edge once real pin data has flushed through and ncs was high.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt_r <= {FL_W{1'b0}};
         armed_r     <= 1'b0;
      end else begin
         if (!flush_done_s) begin
            flush_cnt_r <= flush_cnt_r + {{(FL_W-1){1'b0}}, 1'b1};
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
         if (flush_done_s && ncs_s) begin
            armed_r <= 1'b1;
         end else begin
            armed_r <= armed_r;
         end
      end
   end

   // FSM next-state and commit decode
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      shift_en_s  = 1'b0;
      do_wr_s     = 1'b0;
      do_err_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if ((ncs_fall_s || fall_pend_r) && armed_r) begin
               state_nxt_s = ST_SHIFT;
               start_s     = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            // ncs rising wins over a coincident sclk edge; that bit is dropped
            if (ncs_rise_s) begin
               state_nxt_s = ST_COMMIT;
            end else if (sclk_rise_s && !ncs_s) begin
               shift_en_s = 1'b1;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         ST_COMMIT: begin
            state_nxt_s = ST_IDLE;
            if (cnt_r == CNT_FRAME) begin
               if (frame_rw_s && (frame_addr_s < NUM_REGS_A)) begin
                  do_wr_s = 1'b1;
               end else begin
                  do_wr_s = 1'b0;
               end
            end else begin
               do_err_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, shift register and saturating bit counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         shift_r     <= {FRAME_BITS{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         fall_pend_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         // A falling edge during COMMIT is replayed in the next IDLE cycle
         fall_pend_r <= (state_r == ST_COMMIT) && ncs_fall_s;
         if (start_s) begin
            shift_r <= {FRAME_BITS{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
         end else if (shift_en_s) begin
            shift_r <= {shift_r[FRAME_BITS-2:0], copi_s};
            if (cnt_r != CNT_MAX) begin
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               cnt_r <= cnt_r;
            end
         end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
         end
      end
   end

   // Register file and status outputs, all updated on the commit edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 5; i++) begin
            regs_r[i] <= 8'h00;
         end
         wr_strobe_r <= 1'b0;
         wr_addr_r   <= 7'd0;
         frame_err_r <= 1'b0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (do_wr_s && (frame_addr_s == 7'(i))) begin
               regs_r[i] <= frame_data_s;
            end else begin
               regs_r[i] <= regs_r[i];
            end
         end
         wr_strobe_r <= do_wr_s;
         frame_err_r <= do_err_s;
         if (do_wr_s) begin
            wr_addr_r <= frame_addr_s;
         end else begin
            wr_addr_r <= wr_addr_r;
         end
      end
   end

   assign en_reg_out_7_0  = regs_r[0];
   assign en_reg_out_15_8 = regs_r[1];
   assign en_reg_pwm_7_0  = regs_r[2];
   assign en_reg_pwm_15_8 = regs_r[3];
   assign pwm_duty_cycle  = regs_r[4];
   assign wr_strobe       = wr_strobe_r;
   assign wr_addr         = wr_addr_r;
   assign frame_err       = frame_err_r;

endmodule

// File: tb/tb_spi_reg_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_receiver
//
// Drives SPI frames onto the pins and compares the register outputs, the last
// write address and the number of wr_strobe / frame_err cycles against a
// frame-level reference model.
// -----------------------------------------------------------------------------
module tb_spi_reg_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk;
   logic       copi;
   logic       ncs;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;
   logic       wr_strobe;
   logic [6:0] wr_addr;
   logic       frame_err;

   spi_reg_receiver #(.SYNC_STAGES(2), .NUM_REGS(5), .FRAME_BITS(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .wr_strobe       (wr_strobe),
      .wr_addr         (wr_addr),
      .frame_err       (frame_err)
   );

   always #5 clk = ~clk;

   // Counts of cycles in which each pulse output was high
   int strobe_cycles = 0;
   int err_cycles    = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_strobe === 1'b1) strobe_cycles++;
         if (frame_err === 1'b1) err_cycles++;
      end
   end

   // Reference model state
   logic [7:0] exp_regs [5];
   logic [6:0] exp_addr;
   int         exp_strobes;
   int         exp_errs;

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model of one completed frame: word holds the bits sent, n the bit count
   task automatic model_frame(input logic [31:0] word, input int n);
      logic [6:0] a;
      a = word[14:8];
      if (n != 16) begin
         exp_errs++;
      end else if (word[15] == 1'b1 && a < 7'd5) begin
         exp_regs[a] = word[7:0];
         exp_addr    = a;
         exp_strobes++;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
      exp_addr = 7'd0;
   endtask

   task automatic clock_bits(input logic [31:0] word, input int n, input int half);
      for (int i = n - 1; i >= 0; i--) begin
         copi = word[i];
         wait_clks(half);
         sclk = 1'b1;
         wait_clks(half);
         sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [31:0] word, input int n, input int half, input int gap);
      ncs = 1'b0;
      wait_clks(half);
      clock_bits(word, n, half);
      wait_clks(half);
      ncs = 1'b1;
      wait_clks(gap);
      model_frame(word, n);
   endtask

   task automatic check_all(input string tag);
      wait_clks(8);
      chk({tag, ".reg0"}, {24'd0, en_reg_out_7_0},  {24'd0, exp_regs[0]});
      chk({tag, ".reg1"}, {24'd0, en_reg_out_15_8}, {24'd0, exp_regs[1]});
      chk({tag, ".reg2"}, {24'd0, en_reg_pwm_7_0},  {24'd0, exp_regs[2]});
      chk({tag, ".reg3"}, {24'd0, en_reg_pwm_15_8}, {24'd0, exp_regs[3]});
      chk({tag, ".reg4"}, {24'd0, pwm_duty_cycle},  {24'd0, exp_regs[4]});
      chk({tag, ".wr_addr"}, {25'd0, wr_addr}, {25'd0, exp_addr});
      chk({tag, ".strobes"}, strobe_cycles, exp_strobes);
      chk({tag, ".errs"}, err_cycles, exp_errs);
   endtask

   initial begin
      logic [31:0] w;
      int          n;

      exp_strobes = 0;
      exp_errs    = 0;
      model_reset();
      rst  = 1'b1;
      sclk = 1'b0;
      copi = 1'b0;
      ncs  = 1'b1;
      wait_clks(3);
      rst = 1'b0;
      wait_clks(1);
      chk("reset.wr_strobe", {31'd0, wr_strobe}, 32'd0);
      chk("reset.frame_err", {31'd0, frame_err}, 32'd0);
      check_all("reset");

      // Basic writes
      send_frame(32'h80F0, 16, 6, 6);
      check_all("w80F0");
      send_frame(32'h8480, 16, 6, 6);
      check_all("w8480");
      send_frame(32'h83FF, 16, 6, 6);
      check_all("w83FF");

      // Out-of-range address and read frame
      send_frame(32'hB055, 16, 6, 6);
      check_all("wB055");
      send_frame(32'h0155, 16, 6, 6);
      check_all("r0155");

      // Bad bit counts
      send_frame(32'h000002AB, 10, 6, 6);
      check_all("short10");
      send_frame(32'h00081234, 20, 6, 6);
      check_all("long20");
      send_frame(32'h0, 0, 6, 6);
      check_all("zero");

      // Reset in the middle of a frame with ncs held low
      send_frame(32'h81AA, 16, 6, 6);
      check_all("w81AA");
      ncs = 1'b0;
      wait_clks(6);
      clock_bits(32'h81, 8, 6);
      rst = 1'b1;
      wait_clks(1);
      rst = 1'b0;
      model_reset();
      wait_clks(1);
      chk("midrst.reg1", {24'd0, en_reg_out_15_8}, 32'h00);
      clock_bits(32'h55, 8, 6);
      wait_clks(6);
      ncs = 1'b1;
      wait_clks(6);
      check_all("abandoned");
      send_frame(32'h8133, 16, 6, 6);
      check_all("w8133");

      // Minimum sclk half-period and minimum ncs gap, back to back
      send_frame(32'h8201, 16, 4, 4);
      send_frame(32'h8302, 16, 4, 4);
      check_all("b2b");

      // Randomised frames: mixed R/W, addresses around the limit, odd lengths
      for (int k = 0; k < 16; k++) begin
         w = $urandom;
         w[14:8] = 7'($urandom_range(0, 6));
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : 16;
         send_frame(w, n, int'($urandom_range(4, 7)), int'($urandom_range(4, 8)));
         check_all($sformatf("rnd%0d", k));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
